// File: rtl/apv_trig_decoder_if.sv
// Signal bundle between the APV trigger loopback monitor and its user:
// the serial line and control inputs in, decode strobes and counters out.
interface apv_trig_decoder_if;
   logic        APV_TRG;
   logic [7:0]  MIN_RST_GAP;
   logic        CLR_CNT;
   logic        TRIG_OUT;
   logic        RESET_OUT;
   logic        CALIB_OUT;
   logic        ERR_OUT;
   logic        EARLY_OUT;
   logic        BUSY;
   logic [31:0] TRIG_CNT;
   logic [15:0] RESET_CNT;
   logic [15:0] CALIB_CNT;
   logic [15:0] ERR_CNT;
   logic [15:0] EARLY_CNT;
   logic [7:0]  CAL_LAT;

   modport master (
      output APV_TRG, MIN_RST_GAP, CLR_CNT,
      input  TRIG_OUT, RESET_OUT, CALIB_OUT, ERR_OUT, EARLY_OUT, BUSY,
      input  TRIG_CNT, RESET_CNT, CALIB_CNT, ERR_CNT, EARLY_CNT, CAL_LAT
   );

   modport slave (
      input  APV_TRG, MIN_RST_GAP, CLR_CNT,
      output TRIG_OUT, RESET_OUT, CALIB_OUT, ERR_OUT, EARLY_OUT, BUSY,
      output TRIG_CNT, RESET_CNT, CALIB_CNT, ERR_CNT, EARLY_CNT, CAL_LAT
   );
endinterface

// File: rtl/apv_trig_decoder.sv
// APV25 3-bit trigger line decoder. Collects words that start with a 1,
// decodes 100/101/110/111 into one-cycle strobes, keeps event counters,
// guards triggers that follow a reset101 too closely and measures the
// calibrate-to-trigger latency.
module apv_trig_decoder #(
   parameter bit SYNC_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   apv_trig_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B1   = 2'd1,
      B2   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        s;
   logic        word_done;
   logic        b1_q;
   logic        word_vld_q;
   logic [1:0]  word_code_q;
   logic        is_trig, is_rst, is_cal, is_err;
   logic        trig_acc, trig_early;
   logic [7:0]  since_q, since_nxt;
   logic [7:0]  cal_run_q, cal_nxt;
   logic        armed_q;
   logic [7:0]  cal_lat_q;
   logic        trig_q, rst_q, cal_q, err_q, early_q;
   logic [31:0] trig_cnt_q;
   logic [15:0] rst_cnt_q, cal_cnt_q, err_cnt_q, early_cnt_q;

   generate
      if (SYNC_EN) begin : g_sync
         logic [1:0] sync_q;
         // Two-flop synchronizer for the asynchronous trigger line.
         // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) sync_q <= 2'b00;
            else     sync_q <= {sync_q[0], bus.APV_TRG};
         end
         assign s = sync_q[1];
      end else begin : g_direct
         assign s = bus.APV_TRG;
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Word framing: a leading 1 opens a word, two more bits complete it.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      word_done = 1'b0;
      case (state_q)
         IDLE:    if (s) state_d = B1;
         B1:      state_d = B2;
         B2: begin
            state_d   = IDLE;
            word_done = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the two payload bits; the completed word is decoded next cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         b1_q        <= 1'b0;
         word_vld_q  <= 1'b0;
         word_code_q <= 2'b00;
      end else begin
         if (state_q == B1) b1_q <= s;
         word_vld_q <= word_done;
         if (word_done) word_code_q <= {b1_q, s};
      end
   end

   // Counter values as they will stand after this edge, so a trigger exactly
   // MIN_RST_GAP cycles after RESET_OUT passes the guard and CAL_LAT reads the
   // full strobe-to-strobe distance.
   assign since_nxt  = (since_q == 8'hFF)   ? 8'hFF : since_q + 8'd1;
   assign cal_nxt    = (cal_run_q == 8'hFF) ? 8'hFF : cal_run_q + 8'd1;

   assign is_trig    = word_vld_q && (word_code_q == 2'b00);
   assign is_rst     = word_vld_q && (word_code_q == 2'b01);
   assign is_cal     = word_vld_q && (word_code_q == 2'b10);
   assign is_err     = word_vld_q && (word_code_q == 2'b11);
   assign trig_acc   = is_trig && (since_nxt >= bus.MIN_RST_GAP);
   assign trig_early = is_trig && !(since_nxt >= bus.MIN_RST_GAP);

   // One-cycle decode strobes; at most one word completes per cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         trig_q  <= 1'b0;
         rst_q   <= 1'b0;
         cal_q   <= 1'b0;
         err_q   <= 1'b0;
         early_q <= 1'b0;
      end else begin
         trig_q  <= trig_acc;
         rst_q   <= is_rst;
         cal_q   <= is_cal;
         err_q   <= is_err;
         early_q <= trig_early;
      end
   end

   // Event counters; a clear request wins over any increment.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         trig_cnt_q  <= 32'd0;
         rst_cnt_q   <= 16'd0;
         cal_cnt_q   <= 16'd0;
         err_cnt_q   <= 16'd0;
         early_cnt_q <= 16'd0;
      end else if (bus.CLR_CNT) begin
         trig_cnt_q  <= 32'd0;
         rst_cnt_q   <= 16'd0;
         cal_cnt_q   <= 16'd0;
         err_cnt_q   <= 16'd0;
         early_cnt_q <= 16'd0;
      end else begin
         if (is_rst)        trig_cnt_q  <= 32'd0;
         else if (trig_acc) trig_cnt_q  <= trig_cnt_q + 32'd1;
         if (is_rst)        rst_cnt_q   <= rst_cnt_q + 16'd1;
         if (is_cal)        cal_cnt_q   <= cal_cnt_q + 16'd1;
         if (is_err)        err_cnt_q   <= err_cnt_q + 16'd1;
         if (trig_early)    early_cnt_q <= early_cnt_q + 16'd1;
      end
   end

   // Cycles since the last reset101; deliberately untouched by CLR_CNT.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)         since_q <= 8'd0;
      else if (is_rst) since_q <= 8'd0;
      else             since_q <= since_nxt;
   end

   // Calibrate-to-trigger latency: armed by calibrate, latched by an accepted trigger.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cal_run_q <= 8'd0;
         armed_q   <= 1'b0;
         cal_lat_q <= 8'd0;
      end else begin
         if (is_cal)       cal_run_q <= 8'd0;
         else if (armed_q) cal_run_q <= cal_nxt;
         if (bus.CLR_CNT) begin
            armed_q   <= 1'b0;
            cal_lat_q <= 8'd0;
         end else if (is_cal) begin
            armed_q   <= 1'b1;
         end else if (trig_acc && armed_q) begin
            cal_lat_q <= cal_nxt;
            armed_q   <= 1'b0;
         end
      end
   end

   assign bus.TRIG_OUT  = trig_q;
   assign bus.RESET_OUT = rst_q;
   assign bus.CALIB_OUT = cal_q;
   assign bus.ERR_OUT   = err_q;
   assign bus.EARLY_OUT = early_q;
   assign bus.BUSY      = (state_q != IDLE);
   assign bus.TRIG_CNT  = trig_cnt_q;
   assign bus.RESET_CNT = rst_cnt_q;
   assign bus.CALIB_CNT = cal_cnt_q;
   assign bus.ERR_CNT   = err_cnt_q;
   assign bus.EARLY_CNT = early_cnt_q;
   assign bus.CAL_LAT   = cal_lat_q;

endmodule

// File: tb/tb_apv_trig_decoder.sv
// Scoreboard bench for apv_trig_decoder: one instance without and one with
// the input synchronizer. Each driven word is turned into an expected event
// (strobe edge, strobe kind, counter snapshot) by an edge-time model; a
// monitor pops and compares whenever a strobe appears.
module tb_apv_trig_decoder;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   apv_trig_decoder_if bus0 ();
   apv_trig_decoder_if bus1 ();

   apv_trig_decoder #(.SYNC_EN(1'b0)) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
   apv_trig_decoder #(.SYNC_EN(1'b1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

   always #5 CLK = ~CLK;

   int edge_n = 0;
   always @(posedge CLK) edge_n <= edge_n + 1;

   // Strobe bit order: {EARLY, ERR, CALIB, RESET, TRIG}
   typedef struct {
      int          edge_no;
      logic [4:0]  stb;
      logic [31:0] trig_cnt;
      logic [15:0] rst_cnt;
      logic [15:0] cal_cnt;
      logic [15:0] err_cnt;
      logic [15:0] early_cnt;
      logic [7:0]  cal_lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Reference model state, per instance, in terms of event edge times.
   logic [31:0] m_trig[2];
   logic [15:0] m_rst[2], m_cal[2], m_err[2], m_early[2];
   logic [7:0]  m_lat[2];
   logic [7:0]  m_gap[2];
   bit          m_armed[2];
   int          m_r_edge[2], m_c_edge[2];

   int n_checks = 0;
   int n_errors = 0;
   int busy_cnt0 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic mon_step(input int inst, input logic [4:0] stb, input logic [31:0] tc,
                           input logic [15:0] rc, input logic [15:0] cc, input logic [15:0] ec,
                           input logic [15:0] yc, input logic [7:0] lat);
      exp_t e;
      int   sz;
      sz = (inst == 0) ? q0.size() : q1.size();
      if (stb != 5'b0) begin
         if (sz == 0) begin
            check($sformatf("dut%0d_unexpected_strobe", inst), {27'b0, stb}, 32'd0);
         end else begin
            if (inst == 0) e = q0.pop_front();
            else           e = q1.pop_front();
            check($sformatf("dut%0d_strobe_kind", inst), {27'b0, stb}, {27'b0, e.stb});
            check($sformatf("dut%0d_strobe_edge", inst), edge_n, e.edge_no);
            check($sformatf("dut%0d_trig_cnt", inst), tc, e.trig_cnt);
            check($sformatf("dut%0d_reset_cnt", inst), {16'b0, rc}, {16'b0, e.rst_cnt});
            check($sformatf("dut%0d_calib_cnt", inst), {16'b0, cc}, {16'b0, e.cal_cnt});
            check($sformatf("dut%0d_err_cnt", inst), {16'b0, ec}, {16'b0, e.err_cnt});
            check($sformatf("dut%0d_early_cnt", inst), {16'b0, yc}, {16'b0, e.early_cnt});
            check($sformatf("dut%0d_cal_lat", inst), {24'b0, lat}, {24'b0, e.cal_lat});
         end
      end else if (sz != 0) begin
         e = (inst == 0) ? q0[0] : q1[0];
         if (edge_n > e.edge_no) begin
            check($sformatf("dut%0d_missed_strobe_edge", inst), edge_n, e.edge_no);
            if (inst == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
         end
      end
   endtask

   // Monitor: compare every strobe against the scoreboard head.
   always @(negedge CLK) begin
      if (!RST) begin
         mon_step(0, {bus0.EARLY_OUT, bus0.ERR_OUT, bus0.CALIB_OUT, bus0.RESET_OUT, bus0.TRIG_OUT},
                  bus0.TRIG_CNT, bus0.RESET_CNT, bus0.CALIB_CNT, bus0.ERR_CNT, bus0.EARLY_CNT, bus0.CAL_LAT);
         mon_step(1, {bus1.EARLY_OUT, bus1.ERR_OUT, bus1.CALIB_OUT, bus1.RESET_OUT, bus1.TRIG_OUT},
                  bus1.TRIG_CNT, bus1.RESET_CNT, bus1.CALIB_CNT, bus1.ERR_CNT, bus1.EARLY_CNT, bus1.CAL_LAT);
         if (bus0.BUSY) busy_cnt0 <= busy_cnt0 + 1;
      end
   end

   task automatic set_trg(input int inst, input logic v);
      if (inst == 0) bus0.APV_TRG = v;
      else           bus1.APV_TRG = v;
   endtask

   task automatic set_gap(input int inst, input logic [7:0] g);
      m_gap[inst] = g;
      if (inst == 0) bus0.MIN_RST_GAP = g;
      else           bus1.MIN_RST_GAP = g;
   endtask

   task automatic idle(input int inst, input int n);
      repeat (n) begin
         @(negedge CLK);
         set_trg(inst, 1'b0);
      end
   endtask

   // Drive one 3-bit word and predict its strobe. The first bit reaches the
   // decoder one edge later (plus two synchronizer edges on instance 1) and
   // the strobe follows three edges after that.
   task automatic drive_word(input int inst, input logic [2:0] w, input bit clr, output int t);
      exp_t e;
      int   k, d;
      @(negedge CLK);
      k = edge_n;
      t = k + 4 + ((inst == 1) ? 2 : 0);
      set_trg(inst, w[2]);
      case (w)
         3'b100: begin
            if (t - m_r_edge[inst] >= int'(m_gap[inst])) begin
               m_trig[inst] = m_trig[inst] + 32'd1;
               e.stb = 5'b00001;
               if (m_armed[inst]) begin
                  d = t - m_c_edge[inst];
                  m_lat[inst]   = (d > 255) ? 8'd255 : 8'(d);
                  m_armed[inst] = 1'b0;
               end
            end else begin
               m_early[inst] = m_early[inst] + 16'd1;
               e.stb = 5'b10000;
            end
         end
         3'b101: begin
            m_rst[inst]    = m_rst[inst] + 16'd1;
            m_trig[inst]   = 32'd0;
            m_r_edge[inst] = t;
            e.stb = 5'b00010;
         end
         3'b110: begin
            m_cal[inst]    = m_cal[inst] + 16'd1;
            m_c_edge[inst] = t;
            m_armed[inst]  = 1'b1;
            e.stb = 5'b00100;
         end
         default: begin
            m_err[inst] = m_err[inst] + 16'd1;
            e.stb = 5'b01000;
         end
      endcase
      if (clr) begin
         m_trig[inst]  = 32'd0;
         m_rst[inst]   = 16'd0;
         m_cal[inst]   = 16'd0;
         m_err[inst]   = 16'd0;
         m_early[inst] = 16'd0;
         m_lat[inst]   = 8'd0;
         m_armed[inst] = 1'b0;
      end
      e.edge_no   = t;
      e.trig_cnt  = m_trig[inst];
      e.rst_cnt   = m_rst[inst];
      e.cal_cnt   = m_cal[inst];
      e.err_cnt   = m_err[inst];
      e.early_cnt = m_early[inst];
      e.cal_lat   = m_lat[inst];
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
      @(negedge CLK);
      set_trg(inst, w[1]);
      @(negedge CLK);
      set_trg(inst, w[0]);
   endtask

   task automatic check_all_zero(input int inst);
      if (inst == 0) begin
         check("dut0_rst_strobes", {27'b0, bus0.EARLY_OUT, bus0.ERR_OUT, bus0.CALIB_OUT, bus0.RESET_OUT, bus0.TRIG_OUT}, 32'd0);
         check("dut0_rst_busy", {31'b0, bus0.BUSY}, 32'd0);
         check("dut0_rst_trig_cnt", bus0.TRIG_CNT, 32'd0);
         check("dut0_rst_other_cnts", {bus0.RESET_CNT | bus0.CALIB_CNT | bus0.ERR_CNT | bus0.EARLY_CNT, 8'b0, bus0.CAL_LAT}, 32'd0);
      end else begin
         check("dut1_rst_strobes", {27'b0, bus1.EARLY_OUT, bus1.ERR_OUT, bus1.CALIB_OUT, bus1.RESET_OUT, bus1.TRIG_OUT}, 32'd0);
         check("dut1_rst_busy", {31'b0, bus1.BUSY}, 32'd0);
         check("dut1_rst_trig_cnt", bus1.TRIG_CNT, 32'd0);
         check("dut1_rst_other_cnts", {bus1.RESET_CNT | bus1.CALIB_CNT | bus1.ERR_CNT | bus1.EARLY_CNT, 8'b0, bus1.CAL_LAT}, 32'd0);
      end
   endtask

   // Assert RST (from a negedge), verify cleared outputs, release and reset the model.
   task automatic apply_reset();
      RST = 1'b1;
      set_trg(0, 1'b0);
      set_trg(1, 1'b0);
      repeat (3) @(negedge CLK);
      check_all_zero(0);
      check_all_zero(1);
      RST = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_trig[i]   = 32'd0;
         m_rst[i]    = 16'd0;
         m_cal[i]    = 16'd0;
         m_err[i]    = 16'd0;
         m_early[i]  = 16'd0;
         m_lat[i]    = 8'd0;
         m_armed[i]  = 1'b0;
         m_r_edge[i] = edge_n;
         m_c_edge[i] = edge_n;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, b, r;
      logic [2:0] w;
      bus0.APV_TRG = 1'b0; bus0.CLR_CNT = 1'b0;
      bus1.APV_TRG = 1'b0; bus1.CLR_CNT = 1'b0;
      set_gap(0, 8'd4);
      set_gap(1, 8'd0);
      apply_reset();
      idle(0, 2);

      // reset101 then trigger; BUSY must cover two cycles per word
      b = busy_cnt0;
      drive_word(0, 3'b101, 1'b0, t);
      idle(0, 10);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);
      check("busy_cycles_two_words", busy_cnt0 - b, 32'd4);

      // five back-to-back triggers, then reset101 clears TRIG_CNT
      repeat (5) drive_word(0, 3'b100, 1'b0, t);
      drive_word(0, 3'b101, 1'b0, t);
      idle(0, 8);

      // reset guard: 10-cycle gap is early, 20-cycle gap is accepted
      set_gap(0, 8'd20);
      drive_word(0, 3'b101, 1'b0, t);
      idle(0, 7);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);
      drive_word(0, 3'b101, 1'b0, t);
      idle(0, 17);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);

      // calibrate latency 37 and a saturating 400
      drive_word(0, 3'b110, 1'b0, t);
      idle(0, 34);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);
      drive_word(0, 3'b110, 1'b0, t);
      idle(0, 397);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);

      // illegal word, then reset in the middle of a reset101
      drive_word(0, 3'b111, 1'b0, t);
      idle(0, 6);
      @(negedge CLK); set_trg(0, 1'b1);
      @(negedge CLK); set_trg(0, 1'b0);
      @(negedge CLK);
      apply_reset();
      set_gap(0, 8'd0);
      drive_word(0, 3'b100, 1'b0, t);
      idle(0, 8);

      // synchronized instance: plain trigger, then one cleared on its strobe edge
      drive_word(1, 3'b100, 1'b0, t);
      idle(1, 8);
      drive_word(1, 3'b100, 1'b1, t);
      while (edge_n < t - 1) @(negedge CLK);
      bus1.CLR_CNT = 1'b1;
      @(negedge CLK);
      bus1.CLR_CNT = 1'b0;
      idle(1, 3);
      check("dut1_trig_cnt_after_clr", bus1.TRIG_CNT, 32'd0);

      // randomized words and gaps against the model
      for (int n = 0; n < 80; n++) begin
         if (n % 16 == 0) begin
            idle(0, 6);
            set_gap(0, 8'($urandom_range(0, 30)));
         end
         r = $urandom_range(0, 9);
         if (r < 5)       w = 3'b100;
         else if (r < 7)  w = 3'b101;
         else if (r < 9)  w = 3'b110;
         else             w = 3'b111;
         drive_word(0, w, 1'b0, t);
         idle(0, $urandom_range(0, 12));
      end

      // line held high decodes as repeated 111
      repeat (3) begin
         drive_word(0, 3'b111, 1'b0, t);
      end
      idle(0, 2);

      for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(negedge CLK);
      check("dut0_events_drained", q0.size(), 32'd0);
      check("dut1_events_drained", q1.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
